data_mem_responder: RTL
=======================

# data_mem_responder

Multi-cycle data-memory responder that serves the CPU's load/store port over a valid/ready request/response handshake, replacing the single-cycle combinational data memory for the stall-capable pipeline. It accepts one word request at a time, models a fixed access latency with a down-counter, commits writes or captures read data, and holds the response until the CPU acknowledges it. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. The hazard unit stalls the pipeline while a response is outstanding.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- LATENCY, 4: number of BUSY cycles per access; at least 1.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU consumes the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  the access was rejected (see Configuration).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid is high, at the clock edge: latch write, addr and wdata; load cnt to LATENCY-1; go to BUSY.
- BUSY:
  - req_ready=0.
  - If cnt≠0, decrement cnt.
  - If cnt==0, at the edge: perform the access and go to RESP.
    - Store: write the latched data to mem[word index].
    - Load: capture mem[word index] into the read-data register.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable.
  - When resp_ready is high, at the edge: go to IDLE.
  - req_valid is ignored in RESP. There is no same-cycle accept.
- Word index = latched_addr[log2(DEPTH_WORDS)+1:2].
- cnt width is clog2(LATENCY) bits, minimum 1.
- Reset values:
  - state=IDLE, cnt=0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - The memory array is not reset; its contents are undefined until written.
- Reset asserted mid-operation: the FSM returns to IDLE immediately.
  - A store still in BUSY is discarded and memory is unchanged.
  - A store already committed (state RESP) is kept.
- Request inputs are sampled only on the accepting edge. Later changes do not affect the in-flight access.

## Timing
- Accept edge E0 (IDLE with req_valid=1).
- BUSY lasts exactly LATENCY cycles.
- The access commits at edge E0+LATENCY.
- resp_valid rises after edge E0+LATENCY.
- With resp_ready held at 1, the handshake completes at edge E0+LATENCY+1. The earliest next accept is edge E0+LATENCY+2.
- Maximum throughput: one access per LATENCY+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- Macro: DMEM_RESP_ERR_CHECK_EN.
- Defined:
  - resp_err=1 when latched_addr[1:0]≠0 or latched_addr ≥ 4·DEPTH_WORDS.
  - On error, a store does not write memory and resp_rdata=0.
  - The response still follows normal latency.
- Undefined:
  - resp_err is tied to 0.
  - addr[1:0] is ignored.
  - Upper address bits are discarded, so addresses wrap modulo 4·DEPTH_WORDS.

## Test plan
All scenarios use DEPTH_WORDS=1024 and LATENCY=4.
- Reset check: drive reset low mid-cycle, then release. Required: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 asynchronously during reset.
- Store then load:
  - Store 0xDEADBEEF to address 0x10 at E0. Required: resp_valid after E0+4, resp_rdata=0, resp_err=0.
  - Then load 0x10. Required: resp_rdata=0xDEADBEEF exactly 4 cycles after its accept.
- Response backpressure: load with resp_ready held low for 7 cycles. Required: resp_valid and resp_rdata stay stable and req_ready stays 0; return to IDLE one edge after resp_ready=1.
- Back-to-back: req_valid held high with 3 loads and resp_ready=1. Required: accepts exactly 6 cycles apart, in order, with correct data.
- Reset mid-access: store 0x12345678 to 0x20, then assert reset in BUSY with cnt=2. Required: back to IDLE; a subsequent load of 0x20 returns the prior value, not 0x12345678.
- Error or wrap:
  - With DMEM_RESP_ERR_CHECK_EN defined: store to 0x1002 gives resp_err=1 and memory is unchanged; load from 0x1000 gives resp_err=1 and resp_rdata=0.
  - Without the macro: store 0xA5A5A5A5 to 0x1000, then load 0x0. Required: 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one word access at a time over valid/ready request/response.
// Optional access checking (misaligned / out-of-range) is enabled with DMEM_RESP_ERR_CHECK_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          mem_we;
    logic          acc_err;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    assign idx = addr_q[AW+1:2];

`ifdef DMEM_RESP_ERR_CHECK_EN
    assign acc_err = (addr_q[1:0] != 2'b00) || (|(addr_q >> (AW + 2)));
`else
    // Without checking, byte offset and upper bits are dropped so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[31:AW+2], addr_q[1:0]};
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Commit edge: rejected accesses neither write nor return data.
                    err_d   = acc_err;
                    mem_we  = wr_q && !acc_err;
                    rdata_d = (wr_q || acc_err) ? 32'h0 : mem[idx];
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; a reset in BUSY leaves state_q at IDLE so mem_we stays low.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wdata_q;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
